// File: rtl/mem_1r1w_sync_init.sv
// 1R1W single-clock memory with registered read, per-lane write mask,
// selectable read-during-write policy and a hardware initialisation sweep.
//
// Port contract:
//   - While init_busy is high every port request (ren, wen, init_req) is
//     ignored and rvalid stays low.
//   - In normal operation a read accepted on one rising edge (ren=1,
//     init_req=0) produces rdata with rvalid=1 during the following cycle
//     only. With no accepted read, rvalid is low and rdata keeps its value.
//   - A write accepted on a rising edge (wen=1, init_req=0) updates only
//     the lanes whose wmask bit is set.
//   - init_req in normal operation drops that cycle's ren/wen and starts a
//     sweep on the next edge.

module mem_1r1w_sync_init #(
    parameter int                    ADDR_WIDTH = 5,
    parameter int                    DATA_WIDTH = 64,
    parameter int                    LANE_WIDTH = 8,
    parameter bit                    RD_BYPASS  = 1'b1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             init_req,
    output logic                             init_busy,
    input  logic                             ren,
    input  logic [ADDR_WIDTH-1:0]            raddr,
    output logic                             rvalid,
    output logic [DATA_WIDTH-1:0]            rdata,
    input  logic                             wen,
    input  logic [ADDR_WIDTH-1:0]            waddr,
    input  logic [DATA_WIDTH-1:0]            wdata,
    input  logic [DATA_WIDTH/LANE_WIDTH-1:0] wmask,
    output logic                             dbg_state
);

    localparam int DEPTH  = 1 << ADDR_WIDTH;
    localparam int NLANES = DATA_WIDTH / LANE_WIDTH;

    // Controller states; exported on dbg_state.
    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    // One extra counter bit so the terminal compare can never alias.
    localparam logic [ADDR_WIDTH:0] CNT_LAST = (ADDR_WIDTH + 1)'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH + 1)'(1);

    // Controller and read-port registers.
    logic [0:0]            state_q, state_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    // Storage array; contents are never reset, only swept.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Decoded request qualifiers and datapath nets.
    logic                  port_active;
    logic                  rd_fire;
    logic                  wr_fire;
    logic                  same_addr;
    logic [DATA_WIDTH-1:0] bit_mask;
    logic [DATA_WIDTH-1:0] stored_word;
    logic [DATA_WIDTH-1:0] merged_word;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_wa;
    logic [DATA_WIDTH-1:0] mem_wd;

    // Ports are honoured only in READY and only when no sweep is requested.
    always_comb begin
        port_active = (state_q == ST_READY) && !init_req;
        rd_fire     = port_active && ren;
        wr_fire     = port_active && wen;
        same_addr   = (raddr == waddr);
    end

    // Expand the lane mask into a per-bit mask.
    always_comb begin
        bit_mask = '0;
        for (int i = 0; i < NLANES; i++) begin
            bit_mask[i*LANE_WIDTH +: LANE_WIDTH] = {LANE_WIDTH{wmask[i]}};
        end
    end

    // Masked merge of incoming data over the currently stored word.
    always_comb begin
        stored_word = mem_q[waddr];
        merged_word = (stored_word & ~bit_mask) | (wdata & bit_mask);
    end

    // Read source: merged word on a same-address collision when bypassing,
    // otherwise the stored word as it was before this edge.
    always_comb begin
        if (RD_BYPASS && wr_fire && same_addr) begin
            rd_word = merged_word;
        end else begin
            rd_word = mem_q[raddr];
        end
    end

    // Array write port: sweep writes during INIT, masked writes in READY.
    always_comb begin
        mem_we = 1'b0;
        mem_wa = waddr;
        mem_wd = merged_word;
        if (state_q == ST_INIT) begin
            mem_we = 1'b1;
            mem_wa = cnt_q[ADDR_WIDTH-1:0];
            mem_wd = INIT_VALUE;
        end else if (wr_fire) begin
            mem_we = 1'b1;
        end
    end

    // Controller next state: sweep every address once, then serve ports.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INIT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            ST_READY: begin
                if (init_req) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    // Read result next state: load on an accepted read, otherwise hold.
    always_comb begin
        rvalid_d = rd_fire;
        rdata_d  = rd_fire ? rd_word : rdata_q;
    end

    // Controller and read registers; reset forces a fresh sweep.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_INIT;
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    // Storage update; not reset, the sweep establishes known contents.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem_q[mem_wa] <= mem_wd;
        end
    end

    assign init_busy = (state_q == ST_INIT);
    assign rvalid    = rvalid_q;
    assign rdata     = rdata_q;
    assign dbg_state = state_q[0];

endmodule
